// File: rtl/rr_gated_arbiter.sv
// -----------------------------------------------------------------------------
// rr_gated_arbiter
//
// N-channel registered round-robin arbiter with a registered inhibit path.
// The grant is a registered function of the requests and of the inhibit flag
// as it stood before the deciding edge; the inhibit flag is itself a
// registered OR of two block sources. With LOCK_MODE=1 a grant is held while
// its holder keeps requesting, bounded by MAX_HOLD consecutive cycles.
//
// Ports:
//   clk        in   1    rising-edge clock
//   rst_n      in   1    asynchronous active-low reset
//   req        in   N    per-channel level request
//   block_a    in   1    inhibit source A
//   block_b    in   1    inhibit source B
//   gnt        out  N    registered one-hot grant (zero when none)
//   gnt_valid  out  1    registered, high iff gnt is non-zero
//   gnt_idx    out  IW   registered index of granted channel (holds when idle)
//   inhibit_q  out  1    registered block_a | block_b
// -----------------------------------------------------------------------------
module rr_gated_arbiter #(
    parameter int N         = 4,
    parameter int LOCK_MODE = 0,
    parameter int MAX_HOLD  = 8,
    parameter int IW        = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          block_a,
    input  logic          block_b,
    output logic [N-1:0]  gnt,
    output logic          gnt_valid,
    output logic [IW-1:0] gnt_idx,
    output logic          inhibit_q
);

    // Hold counter is wide enough to reach MAX_HOLD and still saturate
    // cleanly when MAX_HOLD=0 (unlimited).
    localparam int HW = $clog2(MAX_HOLD + 2);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_n;
    logic [N-1:0]  r_gnt;
    logic [N-1:0]  w_gnt_n;
    logic          r_valid;
    logic          w_valid_n;
    logic [IW-1:0] r_idx;
    logic [IW-1:0] w_idx_n;
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] w_ptr_n;
    logic [HW-1:0] r_hold_cnt;
    logic [HW-1:0] w_hold_cnt_n;
    logic          r_inhibit;

    logic          w_win_found;
    logic [IW-1:0] w_win_idx;
    logic          w_hold_ok;

    // Round-robin scan starting at the pointer; returns {found, index}.
    // The ternary form keeps the scan free of priority if-chains.
    function automatic logic [IW:0] rr_pick(input logic [N-1:0] r,
                                            input logic [IW-1:0] p);
        logic          found;
        logic [IW-1:0] idx;
        int            j;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            j     = int'(p) + k;
            j     = (j >= N) ? (j - N) : j;
            idx   = (!found && r[j]) ? IW'(j) : idx;
            found = found | r[j];
        end
        return {found, idx};
    endfunction

    // Arbitration winner for the current requests and pointer.
    always_comb begin
        {w_win_found, w_win_idx} = rr_pick(req, r_ptr);
    end

    // Next-state and next-output decision; inhibit has top priority, then
    // continuing a legal hold, then a fresh (or re-)grant from the scan.
    always_comb begin
        w_gnt_n      = r_gnt;
        w_valid_n    = r_valid;
        w_idx_n      = r_idx;
        w_ptr_n      = r_ptr;
        w_state_n    = r_state;
        w_hold_cnt_n = r_hold_cnt;
        w_hold_ok    = (LOCK_MODE != 0) && (r_state == HOLD) && req[r_idx] &&
                       ((MAX_HOLD == 0) || (r_hold_cnt < HW'(MAX_HOLD)));
        if (r_inhibit) begin
            w_gnt_n      = '0;
            w_valid_n    = 1'b0;
            w_state_n    = IDLE;
            w_hold_cnt_n = '0;
        end else if (w_hold_ok) begin
            w_hold_cnt_n = (r_hold_cnt == {HW{1'b1}}) ? r_hold_cnt
                                                      : r_hold_cnt + HW'(1);
        end else if (w_win_found) begin
            // Release without a bubble: the pointer already sits past the
            // old holder, so it naturally gets lowest priority here.
            w_gnt_n            = '0;
            w_gnt_n[w_win_idx] = 1'b1;
            w_valid_n          = 1'b1;
            w_idx_n            = w_win_idx;
            w_ptr_n            = (w_win_idx == IW'(N - 1)) ? '0
                                                           : w_win_idx + IW'(1);
            w_state_n          = (LOCK_MODE != 0) ? HOLD : IDLE;
            w_hold_cnt_n       = (LOCK_MODE != 0) ? HW'(1) : '0;
        end else begin
            w_gnt_n      = '0;
            w_valid_n    = 1'b0;
            w_state_n    = IDLE;
            w_hold_cnt_n = '0;
        end
    end

    // State, grant, pointer and inhibit registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_gnt      <= '0;
            r_valid    <= 1'b0;
            r_idx      <= '0;
            r_ptr      <= '0;
            r_hold_cnt <= '0;
            r_inhibit  <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_gnt      <= w_gnt_n;
            r_valid    <= w_valid_n;
            r_idx      <= w_idx_n;
            r_ptr      <= w_ptr_n;
            r_hold_cnt <= w_hold_cnt_n;
            r_inhibit  <= block_a | block_b;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_valid = r_valid;
    assign gnt_idx   = r_idx;
    assign inhibit_q = r_inhibit;

endmodule

// File: tb/tb_rr_gated_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_gated_arbiter
//
// Three instances of rr_gated_arbiter (N=4): free round-robin, lock mode with
// MAX_HOLD=3, lock mode with unlimited hold. Directed vectors (inputs plus
// expected outputs) run through a scoreboard queue, then a hand-written
// asynchronous reset sequence, then a random run checking grant legality.
// -----------------------------------------------------------------------------
module tb_rr_gated_arbiter;

    logic       clk;
    logic       rst_n;
    logic [3:0] req_s [3];
    logic       ba_s  [3];
    logic       bb_s  [3];
    logic [3:0] gnt_s [3];
    logic       gv_s  [3];
    logic [1:0] idx_s [3];
    logic       iq_s  [3];

    typedef struct {
        int         sel;
        bit         pre_rst;
        logic [3:0] req;
        logic       ba;
        logic       bb;
        logic [3:0] gnt;
        logic       gv;
        logic [1:0] idx;
        logic       iq;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   n_checks;
    int   n_fail;

    rr_gated_arbiter #(.N(4), .LOCK_MODE(0), .MAX_HOLD(8)) u_rr (
        .clk(clk), .rst_n(rst_n), .req(req_s[0]), .block_a(ba_s[0]),
        .block_b(bb_s[0]), .gnt(gnt_s[0]), .gnt_valid(gv_s[0]),
        .gnt_idx(idx_s[0]), .inhibit_q(iq_s[0]));

    rr_gated_arbiter #(.N(4), .LOCK_MODE(1), .MAX_HOLD(3)) u_lk3 (
        .clk(clk), .rst_n(rst_n), .req(req_s[1]), .block_a(ba_s[1]),
        .block_b(bb_s[1]), .gnt(gnt_s[1]), .gnt_valid(gv_s[1]),
        .gnt_idx(idx_s[1]), .inhibit_q(iq_s[1]));

    rr_gated_arbiter #(.N(4), .LOCK_MODE(1), .MAX_HOLD(0)) u_lk0 (
        .clk(clk), .rst_n(rst_n), .req(req_s[2]), .block_a(ba_s[2]),
        .block_b(bb_s[2]), .gnt(gnt_s[2]), .gnt_valid(gv_s[2]),
        .gnt_idx(idx_s[2]), .inhibit_q(iq_s[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void add(int sel, bit pr, logic [3:0] rq, logic a,
                                logic b, logic [3:0] g, logic v,
                                logic [1:0] ix, logic q);
        vec_t t;
        t.sel = sel; t.pre_rst = pr; t.req = rq; t.ba = a; t.bb = b;
        t.gnt = g; t.gv = v; t.idx = ix; t.iq = q;
        tbl.push_back(t);
    endfunction

    task automatic note_fail(string msg);
        n_fail++;
        if (n_fail <= 30) $display("FAIL %s", msg);
    endtask

    task automatic check_out(vec_t e, string tag);
        n_checks++;
        if (gnt_s[e.sel] !== e.gnt || gv_s[e.sel] !== e.gv ||
            idx_s[e.sel] !== e.idx || iq_s[e.sel] !== e.iq)
            note_fail($sformatf("%s dut%0d: got gnt=%b v=%b idx=%0d iq=%b, want gnt=%b v=%b idx=%0d iq=%b",
                      tag, e.sel, gnt_s[e.sel], gv_s[e.sel], idx_s[e.sel],
                      iq_s[e.sel], e.gnt, e.gv, e.idx, e.iq));
    endtask

    // Called just after an edge; drives one vector, pushes its expectation,
    // and checks it one edge later.
    task automatic apply(vec_t v, string tag);
        if (v.pre_rst) begin
            rst_n = 1'b0;
            #2;
            rst_n = 1'b1;
        end
        for (int d = 0; d < 3; d++) begin
            req_s[d] = 4'b0000; ba_s[d] = 1'b0; bb_s[d] = 1'b0;
        end
        req_s[v.sel] = v.req; ba_s[v.sel] = v.ba; bb_s[v.sel] = v.bb;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        check_out(exp_q.pop_front(), tag);
    endtask

    initial begin
        vec_t       z;
        logic [3:0] rr [3];
        logic       ra [3];
        logic       rb [3];
        logic       p_iq [3];
        logic [1:0] p_idx [3];
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        for (int d = 0; d < 3; d++) begin
            req_s[d] = 4'b0000; ba_s[d] = 1'b0; bb_s[d] = 1'b0;
        end

        // ---------------- round robin / inhibit (free mode) ----------------
        add(0, 1'b1, 4'b1111, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0);
        add(0, 1'b0, 4'b1111, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b0);
        add(0, 1'b0, 4'b1111, 1'b0, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b0);
        add(0, 1'b0, 4'b1111, 1'b0, 1'b0, 4'b1000, 1'b1, 2'd3, 1'b0);
        add(0, 1'b0, 4'b1111, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0);
        add(0, 1'b1, 4'b0101, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0);
        add(0, 1'b0, 4'b0101, 1'b0, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b0);
        add(0, 1'b0, 4'b0101, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0);
        add(0, 1'b0, 4'b0101, 1'b0, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b0);
        add(0, 1'b0, 4'b1111, 1'b0, 1'b1, 4'b1000, 1'b1, 2'd3, 1'b1);
        add(0, 1'b0, 4'b1111, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd3, 1'b1);
        add(0, 1'b0, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd3, 1'b0);
        add(0, 1'b0, 4'b1111, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0);
        add(0, 1'b0, 4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b1);
        add(0, 1'b0, 4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd1, 1'b0);
        add(0, 1'b0, 4'b1111, 1'b0, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b0);
        add(0, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b0);
        add(0, 1'b0, 4'b0001, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0);
        add(0, 1'b0, 4'b1000, 1'b0, 1'b0, 4'b1000, 1'b1, 2'd3, 1'b0);
        // ---------------- lock mode, MAX_HOLD=3 ----------------
        add(1, 1'b1, 4'b0011, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0);
        add(1, 1'b0, 4'b0011, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0);
        add(1, 1'b0, 4'b0011, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0);
        add(1, 1'b0, 4'b0011, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b0);
        add(1, 1'b0, 4'b0011, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b0);
        add(1, 1'b0, 4'b0011, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b0);
        add(1, 1'b0, 4'b0011, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0);
        for (int i = 0; i < 4; i++)
            add(1, 1'b0, 4'b0001, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0);
        add(1, 1'b0, 4'b0001, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b1);
        add(1, 1'b0, 4'b0011, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0);
        add(1, 1'b0, 4'b0011, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b0);
        add(1, 1'b0, 4'b0011, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b0);
        add(1, 1'b0, 4'b0011, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b0);
        add(1, 1'b0, 4'b0011, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0);
        // ---------------- lock mode, unlimited hold ----------------
        add(2, 1'b1, 4'b0100, 1'b0, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b0);
        add(2, 1'b0, 4'b0101, 1'b0, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b0);
        add(2, 1'b0, 4'b0001, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0);
        for (int i = 0; i < 20; i++)
            add(2, 1'b0, 4'b0001, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b0);
        add(2, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0);
        add(2, 1'b0, 4'b0010, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b0);
        add(2, 1'b0, 4'b0011, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b0);
        add(2, 1'b0, 4'b0010, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b0);

        // Reset state, sampled while rst_n is still low.
        #16;
        z.req = 4'b0000; z.ba = 1'b0; z.bb = 1'b0; z.pre_rst = 1'b0;
        z.gnt = 4'b0000; z.gv = 1'b0; z.idx = 2'd0; z.iq = 1'b0;
        for (int d = 0; d < 3; d++) begin
            z.sel = d;
            check_out(z, "reset_state");
        end
        rst_n = 1'b1;

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // ---------------- asynchronous reset mid-operation ----------------
        z.sel = 0; z.pre_rst = 1'b1; z.req = 4'b1111;
        z.gnt = 4'b0001; z.gv = 1'b1; z.idx = 2'd0;
        apply(z, "arst_pre0");
        z.pre_rst = 1'b0; z.gnt = 4'b0010; z.idx = 2'd1;
        apply(z, "arst_pre1");
        z.gnt = 4'b0100; z.idx = 2'd2;
        apply(z, "arst_pre2");
        rst_n = 1'b0;
        #2;
        z.gnt = 4'b0000; z.gv = 1'b0; z.idx = 2'd0;
        check_out(z, "arst_immediate");
        #2;
        rst_n = 1'b1;
        z.gnt = 4'b0001; z.gv = 1'b1; z.idx = 2'd0;
        apply(z, "arst_first");
        z.gnt = 4'b0010; z.idx = 2'd1;
        apply(z, "arst_second");

        // ---------------- random legality run ----------------
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        for (int c = 0; c < 10000; c++) begin
            for (int d = 0; d < 3; d++) begin
                rr[d]    = 4'($urandom_range(0, 15));
                ra[d]    = ($urandom_range(0, 7) == 0);
                rb[d]    = ($urandom_range(0, 7) == 0);
                p_iq[d]  = iq_s[d];
                p_idx[d] = idx_s[d];
                req_s[d] = rr[d]; ba_s[d] = ra[d]; bb_s[d] = rb[d];
            end
            @(posedge clk);
            #1;
            for (int d = 0; d < 3; d++) begin
                n_checks++;
                if (!$onehot0(gnt_s[d]) || ((gnt_s[d] & ~rr[d]) != 4'b0000) ||
                    (gv_s[d] !== (gnt_s[d] != 4'b0000)) ||
                    (gv_s[d] && (gnt_s[d] !== (4'b0001 << idx_s[d]))))
                    note_fail($sformatf("rand_legal dut%0d cyc%0d: got gnt=%b v=%b idx=%0d, want one-hot subset of req=%b",
                              d, c, gnt_s[d], gv_s[d], idx_s[d], rr[d]));
                n_checks++;
                if (iq_s[d] !== (ra[d] | rb[d]))
                    note_fail($sformatf("rand_iq dut%0d cyc%0d: got %b, want %b",
                              d, c, iq_s[d], ra[d] | rb[d]));
                if (p_iq[d]) begin
                    n_checks++;
                    if (gnt_s[d] !== 4'b0000)
                        note_fail($sformatf("rand_blank dut%0d cyc%0d: got gnt=%b, want 0000",
                                  d, c, gnt_s[d]));
                end
                if (!p_iq[d] && rr[d] != 4'b0000) begin
                    n_checks++;
                    if (gv_s[d] !== 1'b1)
                        note_fail($sformatf("rand_conserve dut%0d cyc%0d: got v=%b, want 1 (req=%b)",
                                  d, c, gv_s[d], rr[d]));
                end
                if (gv_s[d] === 1'b0) begin
                    n_checks++;
                    if (idx_s[d] !== p_idx[d])
                        note_fail($sformatf("rand_idx_hold dut%0d cyc%0d: got %0d, want %0d",
                                  d, c, idx_s[d], p_idx[d]));
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
